adc_scan_sched: RTL
===================

// Module: adc_scan_sched
// PURPOSE
//  Scan scheduler in front of adc_ctrl (50 MHz s_clk, serial 8-bit ADC, adc_en start pulse, con_ok done pulse).
//  On every PERIOD tick it steps an external analog mux through CH_NUM channels.
//  For each channel it waits SETTLE cycles, pulses adc_en, then waits for con_ok or a timeout.
//  It latches each result into a per-channel register file that the host reads asynchronously via rd_ch/rd_data.
// PARAMETERS
//  CH_NUM   4      channels scanned per frame (2..16)
//  CH_W     2      width of channel index, clog2(CH_NUM)
//  PERIOD   50000  s_clk cycles between scan ticks (1 ms @ 50 MHz)
//  SETTLE   100    s_clk cycles mux settling before each conversion start
//  TIMEOUT  4096   s_clk cycles allowed from adc_en to con_ok
// PORTS
//  s_clk        in   1     system clock, 50 MHz
//  s_rst        in   1     synchronous reset, active-high
//  scan_en      in   1     level; 1 = periodic scanning enabled
//  adc_en       out  1     one-cycle start pulse to adc_ctrl
//  adc_dout     in   8     conversion result from adc_ctrl, valid with adc_con_ok
//  adc_con_ok   in   1     one-cycle conversion-done pulse from adc_ctrl
//  mux_sel      out  CH_W  analog mux channel select
//  smp_vld      out  1     one-cycle pulse: smp_ch/smp_data updated
//  smp_ch       out  CH_W  channel of the last stored sample
//  smp_data     out  8     last stored sample
//  scan_done    out  1     one-cycle pulse after the last channel of a frame
//  busy         out  1     1 whenever FSM != IDLE
//  rd_ch        in   CH_W  register-file read address
//  rd_data      out  8     combinational read of result[rd_ch]
//  err_tmo      out  CH_NUM sticky per-channel timeout flags; cleared by reset only
//  err_ovr      out  1     sticky: tick arrived while busy; cleared by reset only
// BEHAVIOUR
//  Reset: all outputs 0, mux_sel=0, result regs=0, tick counter=0, FSM=IDLE.
//  Tick counter runs only while scan_en=1; tick asserts when counter==PERIOD-1, then counter wraps to 0.
//    scan_en=0 holds the counter at 0.
//  FSM states:
//    IDLE:   on tick -> ch=0 -> SETTLE.
//    SETTLE: mux_sel=ch; count SETTLE cycles -> START.
//    START:  adc_en=1 for exactly this cycle -> CONV; timeout counter cleared.
//    CONV:   on adc_con_ok, capture adc_dout -> STORE.
//            Otherwise, when the timeout counter reaches TIMEOUT-1 -> set err_tmo[ch], result unchanged -> NEXT.
//            If con_ok and timeout coincide, con_ok wins.
//    STORE:  write result[ch]; smp_vld=1 with smp_ch=ch, smp_data -> NEXT.
//    NEXT:   if ch==CH_NUM-1 or scan_en==0 -> scan_done=1 -> IDLE; else ch+1 -> SETTLE.
//  Each channel slot: SETTLE + 1 + conversion + 2 cycles.
//  Tick outside IDLE: ignored; sets err_ovr.
//  scan_en falling mid-frame: the current conversion always completes (adc_ctrl is never abandoned).
//    The frame then ends in NEXT with scan_done.
//  adc_con_ok outside CONV: ignored.
//  s_rst mid-conversion: FSM to IDLE immediately; a late con_ok is ignored.
//  rd_data: rd_ch >= CH_NUM returns 8'h00.
// CONFIGURATION
//  ADC_AVG_EN defined:
//    Each channel slot performs 4 back-to-back START/CONV pairs; SETTLE applies only before the first.
//    Samples accumulate into a 10-bit sum; stored value = sum[9:2] (truncate).
//    One smp_vld per channel.
//    A timeout on any of the 4 conversions aborts the channel: err_tmo set, result unchanged.
//  ADC_AVG_EN undefined: one conversion per channel; no accumulator is synthesized.
// STRUCTURE
//  Package adc_pkg:
//    state encoding localparams (IDLE, SETTLE, START, CONV, STORE, NEXT)
//    ADC_DW=8, AVG_N=4, AVG_SW=10
//  Sub-module adc_tick_gen: PERIOD counter with enable -> tick; instantiated once.
//  Register file and FSM stay in adc_scan_sched.
// TESTING
//  Bench parameters: PERIOD=2000, SETTLE=4, TIMEOUT=64.
//  The bench models adc_ctrl: con_ok 20 cycles after adc_en.
//  1 Nominal frame: scan_en=1, model returns 8'h10+ch.
//    -> mux_sel 0,1,2,3 in order; 4 smp_vld; scan_done.
//    -> rd_data reads 10,11,12,13; err_tmo=0.
//  2 Timeout: model silent on ch2.
//    -> adc_en->NEXT after 64 cycles; err_tmo=4'b0100; result[2] keeps its old value.
//    -> ch3 still converted.
//  3 Overrun: PERIOD=50 < frame length.
//    -> err_ovr=1; no frame restarts mid-scan.
//  4 scan_en dropped during ch1 CONV.
//    -> ch1 stored, scan_done, IDLE; no ch2 adc_en.
//  5 s_rst asserted mid-CONV, con_ok arrives 3 cycles later.
//    -> outputs 0, no smp_vld, no STORE.
//  6 ADC_AVG_EN: model returns 8'h10, 8'h11, 8'h12, 8'h13 on ch0.
//    -> 4 adc_en pulses; stored value 8'h11; single smp_vld.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared constants and FSM state type for the ADC scan scheduler.
package adc_pkg;

   localparam int ADC_DW = 8;
   localparam int AVG_N  = 4;
   localparam int AVG_SW = 10;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETTLE = 3'd1,
      S_START  = 3'd2,
      S_CONV   = 3'd3,
      S_STORE  = 3'd4,
      S_NEXT   = 3'd5
   } state_e;

endpackage

// File: rtl/adc_tick_gen.sv
// Scan period generator: one-cycle tick every PERIOD clocks while enabled.
module adc_tick_gen #(
   parameter int PERIOD = 50000
) (
   input  logic s_clk_i,
   input  logic s_rst_i,
   input  logic en_i,
   output logic tick_o
);

   localparam int            CW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!en_i || (cnt_q == LAST)) cnt_d = '0;
      else                          cnt_d = cnt_q + 1'b1;
   end

   assign tick_o = en_i && (cnt_q == LAST);

   always_ff @(posedge s_clk_i) begin
      if (s_rst_i) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/adc_scan_sched.sv
// Periodic multi-channel ADC scan scheduler with per-channel result registers.
// ADC_AVG_EN: average four conversions per channel instead of one.
//   state  | meaning
//   IDLE   | waiting for scan tick
//   SETTLE | mux driven, waiting for analog settling
//   START  | one-cycle adc_en to adc_ctrl
//   CONV   | waiting for con_ok or timeout
//   STORE  | write result register, pulse smp_vld
//   NEXT   | advance channel or close frame
module adc_scan_sched
   import adc_pkg::*;
#(
   parameter int CH_NUM  = 4,
   parameter int CH_W    = 2,
   parameter int PERIOD  = 50000,
   parameter int SETTLE  = 100,
   parameter int TIMEOUT = 4096
) (
   input  logic              s_clk_i,
   input  logic              s_rst_i,
   input  logic              scan_en_i,
   output logic              adc_en_o,
   input  logic [7:0]        adc_dout_i,
   input  logic              adc_con_ok_i,
   output logic [CH_W-1:0]   mux_sel_o,
   output logic              smp_vld_o,
   output logic [CH_W-1:0]   smp_ch_o,
   output logic [7:0]        smp_data_o,
   output logic              scan_done_o,
   output logic              busy_o,
   input  logic [CH_W-1:0]   rd_ch_i,
   output logic [7:0]        rd_data_o,
   output logic [CH_NUM-1:0] err_tmo_o,
   output logic              err_ovr_o
);

   localparam int               TMR_MAX   = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
   localparam int               TMR_W     = $clog2(TMR_MAX) + 1;
   localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE - 1);
   localparam logic [TMR_W-1:0] TMO_LD    = TMR_W'(TIMEOUT - 1);
   localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(CH_NUM - 1);

   state_e              state_q, state_d;
   logic [CH_W-1:0]     ch_q, ch_d;
   logic [TMR_W-1:0]    tmr_q, tmr_d;
   logic [CH_NUM-1:0]   err_tmo_q, err_tmo_d;
   logic                err_ovr_q, err_ovr_d;
   logic                smp_vld_q;
   logic [CH_W-1:0]     smp_ch_q;
   logic [ADC_DW-1:0]   smp_data_q;
   logic [ADC_DW-1:0]   result_q [CH_NUM];
   logic [ADC_DW-1:0]   store_val;
   logic                tick;
   logic                store_en;

`ifdef ADC_AVG_EN
   localparam int AW = $clog2(AVG_N);
   logic [AVG_SW-1:0] acc_q, acc_d;
   logic [AW-1:0]     avg_q, avg_d;
   // Divide-by-four by truncation: keep the top ADC_DW bits of the sum.
   assign store_val = acc_q[AVG_SW-1 -: ADC_DW];
`else
   logic [ADC_DW-1:0] samp_q, samp_d;
   assign store_val = samp_q;
`endif

   adc_tick_gen #(.PERIOD(PERIOD)) u_tick (
      .s_clk_i (s_clk_i),
      .s_rst_i (s_rst_i),
      .en_i    (scan_en_i),
      .tick_o  (tick)
   );

   always_comb begin
      state_d     = state_q;
      ch_d        = ch_q;
      tmr_d       = tmr_q;
      err_tmo_d   = err_tmo_q;
      err_ovr_d   = err_ovr_q | (tick && (state_q != S_IDLE));
      store_en    = 1'b0;
      adc_en_o    = 1'b0;
      scan_done_o = 1'b0;
`ifdef ADC_AVG_EN
      acc_d = acc_q;
      avg_d = avg_q;
`else
      samp_d = samp_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (tick) begin
               state_d = S_SETTLE;
               ch_d    = '0;
               tmr_d   = SETTLE_LD;
`ifdef ADC_AVG_EN
               acc_d = '0;
               avg_d = '0;
`endif
            end
         end
         S_SETTLE: begin
            if (tmr_q == '0) state_d = S_START;
            else             tmr_d   = tmr_q - 1'b1;
         end
         S_START: begin
            adc_en_o = 1'b1;
            tmr_d    = TMO_LD;
            state_d  = S_CONV;
         end
         S_CONV: begin
            // con_ok is checked first so it wins a tie with the timeout.
            if (adc_con_ok_i) begin
`ifdef ADC_AVG_EN
               acc_d = acc_q + AVG_SW'(adc_dout_i);
               if (avg_q == AW'(AVG_N - 1)) begin
                  state_d = S_STORE;
               end else begin
                  avg_d   = avg_q + 1'b1;
                  state_d = S_START;
               end
`else
               samp_d  = adc_dout_i;
               state_d = S_STORE;
`endif
            end else if (tmr_q == '0) begin
               err_tmo_d[ch_q] = 1'b1;
               state_d         = S_NEXT;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         S_STORE: begin
            store_en = 1'b1;
            state_d  = S_NEXT;
         end
         S_NEXT: begin
            if ((ch_q == CH_LAST) || !scan_en_i) begin
               scan_done_o = 1'b1;
               state_d     = S_IDLE;
            end else begin
               ch_d    = ch_q + 1'b1;
               tmr_d   = SETTLE_LD;
               state_d = S_SETTLE;
`ifdef ADC_AVG_EN
               acc_d = '0;
               avg_d = '0;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge s_clk_i) begin
      if (s_rst_i) begin
         state_q    <= S_IDLE;
         ch_q       <= '0;
         tmr_q      <= '0;
         err_tmo_q  <= '0;
         err_ovr_q  <= 1'b0;
         smp_vld_q  <= 1'b0;
         smp_ch_q   <= '0;
         smp_data_q <= '0;
         for (int i = 0; i < CH_NUM; i++) result_q[i] <= '0;
`ifdef ADC_AVG_EN
         acc_q <= '0;
         avg_q <= '0;
`else
         samp_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         ch_q      <= ch_d;
         tmr_q     <= tmr_d;
         err_tmo_q <= err_tmo_d;
         err_ovr_q <= err_ovr_d;
         smp_vld_q <= store_en;
         if (store_en) begin
            result_q[ch_q] <= store_val;
            smp_ch_q       <= ch_q;
            smp_data_q     <= store_val;
         end
`ifdef ADC_AVG_EN
         acc_q <= acc_d;
         avg_q <= avg_d;
`else
         samp_q <= samp_d;
`endif
      end
   end

   assign busy_o     = (state_q != S_IDLE);
   assign mux_sel_o  = ch_q;
   assign smp_vld_o  = smp_vld_q;
   assign smp_ch_o   = smp_ch_q;
   assign smp_data_o = smp_data_q;
   assign err_tmo_o  = err_tmo_q;
   assign err_ovr_o  = err_ovr_q;
   assign rd_data_o  = (int'(rd_ch_i) < CH_NUM) ? result_q[rd_ch_i] : '0;

endmodule
